elbeth_mem_arbiter: RTL
=======================

# elbeth_mem_arbiter

Memory-side arbiter directly downstream of the ELBETH core's instruction and data memory ports. It accepts the core's imem (fetch) and dmem (load/store) request/ready handshakes and serialises them onto one single-port synchronous SRAM with 1-cycle read latency. It returns per-port ready/error pulses with read data. Data requests have priority, and a hand-over rule prevents fetch starvation.

## Interface
Parameters:
- RAM_AW, 6, SRAM word-address width; byte address is RAM_AW+2 = 8 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous and active-high
- imem_en  in  1  fetch request valid; held until imem_ready or imem_error
- imem_addr  in  8  fetch byte address
- imem_rw  in  4  byte write mask; 4'b0000 means read
- imem_out_data  in  32  fetch write data (unused when rw = 0)
- imem_in_data  out  32  read data; valid only while imem_ready = 1
- imem_ready  out  1  one-cycle completion pulse
- imem_error  out  1  one-cycle error completion pulse
- dmem_en, dmem_addr, dmem_rw, dmem_out_data, dmem_in_data, dmem_ready, dmem_error: same as the imem_* ports, for the data port
- ram_en  out  1  SRAM access strobe
- ram_we  out  4  SRAM byte write enables
- ram_addr  out  RAM_AW  SRAM word address = byte addr[7:2]
- ram_wdata  out  32  SRAM write data
- ram_rdata  in  32  SRAM read data, valid the cycle after ram_en with ram_we = 0

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Grant is latched as gnt_d (dmem) or gnt_i (imem), with the granted port's addr, rw and data registered at grant time.
- IDLE:
  - dmem_en=1 → grant dmem, go to ACCESS.
  - Otherwise imem_en=1 → grant imem, go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - ram_en=1, ram_we=latched rw, ram_addr=latched addr[7:2], ram_wdata=latched data.
  - Always go to RESP.
- RESP:
  - Assert the granted port's ready (or error).
  - If the *other* port's en=1, grant it and go to ACCESS.
  - Otherwise go to IDLE.
  - The port just served is never re-granted from RESP; its en is still its old request in this cycle.
- imem_in_data = dmem_in_data = ram_rdata (broadcast). The requester qualifies it with its ready.
- Writes (rw≠0) complete with a ready pulse. Read data is don't-care.
- ram_en=0, ram_we=0, ram_addr=0 and ram_wdata=0 outside ACCESS.
- Requests must hold addr/rw/data stable while en=1 and before completion. A request dropped before completion is still carried out if already granted.
- Fairness: dmem wins simultaneous requests in IDLE. imem waits at most one dmem transaction, because RESP hands over.

## Timing
- Latency: request sampled in IDLE at cycle N → ram_en at N+1 → ready/error pulse at N+2.
- Back-to-back alternating ports: one completion every 2 cycles. A single port issuing repeatedly: one every 3 cycles (passes through IDLE).
- ready and error are registered, are exactly one cycle wide, and are mutually exclusive. Neither port ever receives both in the same cycle.
- Reset (any cycle, including mid-transaction): FSM → IDLE, grant cleared, all outputs 0 next cycle. An in-flight transaction is dropped with no pulse, and requesters reissue it.
- Reset values: imem_ready=imem_error=dmem_ready=dmem_error=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.

## Configuration
- ELBETH_MEM_ALIGN_CHECK_EN defined:
  - A granted request with addr[1:0]≠0 is still walked through ACCESS, with ram_en and ram_we forced to 0.
  - It completes in RESP with an error pulse instead of ready.
  - Latency is unchanged, at N+2.
- Not defined:
  - addr[1:0] is ignored and the access goes to word addr[7:2].
  - imem_error and dmem_error are tied to 0.

## Test plan
- Single read: preload word 5 = 32'hDEADBEEF; imem_en=1, addr=8'h14, rw=0 at cycle 0 → ram_en=1, ram_addr=5 at cycle 1; imem_ready=1 with imem_in_data=32'hDEADBEEF at cycle 2.
- Byte write: dmem addr=8'h08, rw=4'b0010, data=32'h0000AB00 → ram_we=4'b0010 at cycle 1, dmem_ready at cycle 2; a later read of 8'h08 returns only byte 1 changed to 8'hAB.
- Simultaneous requests: imem and dmem both asserted in IDLE at cycle 0 → dmem_ready at cycle 2, then imem granted from RESP, imem_ready at cycle 4; no IDLE gap.
- Continuous dmem traffic plus a pending imem request → imem_ready no later than 4 cycles after imem_en rises; ready pulses are always one cycle wide.
- Reset mid-op: assert rst at cycle 1 of a dmem read → no dmem_ready; all outputs 0 at cycle 2. Reissuing the read completes normally 2 cycles after it is re-presented.
- Misaligned access: addr=8'h03 read → with ELBETH_MEM_ALIGN_CHECK_EN: ram_en stays 0, error pulse at cycle 2, no ready. Without the macro: ram_addr=0, ready at cycle 2.

Source files
------------

// File: rtl/elbeth_mem_arbiter.sv
// elbeth_mem_arbiter: serialises imem/dmem requests onto one 1-cycle SRAM.
// Optional: define ELBETH_MEM_ALIGN_CHECK_EN to turn misaligned accesses into error completions.
module elbeth_mem_arbiter #(
  parameter int RAM_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_en,
  input  logic [RAM_AW+1:0] imem_addr,
  input  logic [3:0]        imem_rw,
  input  logic [31:0]       imem_out_data,
  output logic [31:0]       imem_in_data,
  output logic              imem_ready,
  output logic              imem_error,
  input  logic              dmem_en,
  input  logic [RAM_AW+1:0] dmem_addr,
  input  logic [3:0]        dmem_rw,
  input  logic [31:0]       dmem_out_data,
  output logic [31:0]       dmem_in_data,
  output logic              dmem_ready,
  output logic              dmem_error,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic              gnt_d, gnt_i;
  logic              take_d, take_i;
  logic [RAM_AW-1:0] addr_q;
  logic [3:0]        rw_q;
  logic [31:0]       data_q;
  logic              mis_q;
  logic              mis_nxt;

  assign imem_in_data = ram_rdata;
  assign dmem_in_data = ram_rdata;

`ifdef ELBETH_MEM_ALIGN_CHECK_EN
  // Misalignment is judged on the address of whichever port wins the grant.
  always_comb begin
    mis_nxt = 1'b0;
    if (take_d)
      mis_nxt = (dmem_addr[1:0] != 2'b00);
    else if (take_i)
      mis_nxt = (imem_addr[1:0] != 2'b00);
  end
`else
  logic unused_low_addr;
  assign unused_low_addr = ^{imem_addr[1:0], dmem_addr[1:0]};
  assign mis_nxt = 1'b0;
`endif

  // Next-state, grant selection and SRAM strobes.
  always_comb begin
    state_d   = state_q;
    take_d    = 1'b0;
    take_i    = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (dmem_en)
          take_d = 1'b1;
        else if (imem_en)
          take_i = 1'b1;
        if (take_d || take_i)
          state_d = ACCESS;
      end
      ACCESS: begin
        ram_en    = !mis_q;
        ram_we    = mis_q ? 4'b0000 : rw_q;
        ram_addr  = addr_q;
        ram_wdata = data_q;
        state_d   = RESP;
      end
      RESP: begin
        // Hand over to the other port only; the served
        // port's en still reflects its finished request.
        if (gnt_d && imem_en)
          take_i = 1'b1;
        else if (gnt_i && dmem_en)
          take_d = 1'b1;
        state_d = (take_d || take_i) ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant latch and registered completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_d      <= 1'b0;
      gnt_i      <= 1'b0;
      addr_q     <= '0;
      rw_q       <= '0;
      data_q     <= '0;
      mis_q      <= 1'b0;
      imem_ready <= 1'b0;
      dmem_ready <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_d) begin
        gnt_d  <= 1'b1;
        gnt_i  <= 1'b0;
        addr_q <= dmem_addr[RAM_AW+1:2];
        rw_q   <= dmem_rw;
        data_q <= dmem_out_data;
        mis_q  <= mis_nxt;
      end else if (take_i) begin
        gnt_d  <= 1'b0;
        gnt_i  <= 1'b1;
        addr_q <= imem_addr[RAM_AW+1:2];
        rw_q   <= imem_rw;
        data_q <= imem_out_data;
        mis_q  <= mis_nxt;
      end
      imem_ready <= (state_q == ACCESS) && gnt_i && !mis_q;
      dmem_ready <= (state_q == ACCESS) && gnt_d && !mis_q;
    end
  end

`ifdef ELBETH_MEM_ALIGN_CHECK_EN
  // Error pulses replace ready for misaligned grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_error <= 1'b0;
      dmem_error <= 1'b0;
    end else begin
      imem_error <= (state_q == ACCESS) && gnt_i && mis_q;
      dmem_error <= (state_q == ACCESS) && gnt_d && mis_q;
    end
  end
`else
  assign imem_error = 1'b0;
  assign dmem_error = 1'b0;
`endif

endmodule
